// File: rtl/hub75_fb_arbiter.sv
// Frame RAM arbiter for a HUB75 panel: display reads the front bank, host
// writes the back bank, bank swaps are deferred to the next frame boundary.
module hub75_fb_arbiter #(
    parameter int hpixel_p = 64,
    parameter int vpixel_p = 64,
    parameter int data_wd_p = 24,
    parameter int wr_starve_max_p = 4,
    localparam int addr_width_p = $clog2(hpixel_p * vpixel_p)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_rd_req,
    input  logic [addr_width_p-1:0] i_rd_addr,
    output logic                    o_rd_gnt,
    output logic                    o_rd_valid,
    output logic [data_wd_p-1:0]    o_rd_data,
    input  logic                    i_wr_req,
    input  logic [addr_width_p-1:0] i_wr_addr,
    input  logic [data_wd_p-1:0]    i_wr_data,
    output logic                    o_wr_gnt,
    input  logic                    i_swap_req,
    input  logic                    i_frame_done,
    output logic                    o_swap_pending,
    output logic                    o_front_bank,
    output logic                    o_mem_en,
    output logic                    o_mem_we,
    output logic [addr_width_p:0]   o_mem_addr,
    output logic [data_wd_p-1:0]    o_mem_wdata,
    input  logic [data_wd_p-1:0]    i_mem_rdata
);

    localparam int cnt_w = $clog2(wr_starve_max_p + 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } state_t;

    state_t                  state_q, state_d;
    logic [cnt_w-1:0]        starve_q, starve_d;
    logic                    front_q, front_d;
    logic                    pend_q, pend_d;
    logic                    rd_valid_q;
    logic [addr_width_p:0]   addr_q, addr_d;
    logic [data_wd_p-1:0]    wdata_q, wdata_d;
    logic                    rd_elig, wr_elig;
    logic                    rd_win, wr_win;
    logic                    starve_full;

    // A requester granted this cycle is masked so its stale request is not re-granted.
    always_comb begin
        rd_elig     = i_rd_req && (state_q != RD);
        wr_elig     = i_wr_req && (state_q != WR);
        starve_full = (starve_q == cnt_w'(wr_starve_max_p));
        wr_win      = wr_elig && (starve_full || !rd_elig);
        rd_win      = rd_elig && !wr_win;
    end

    always_comb begin
        front_d = front_q;
        pend_d  = pend_q;
        if (i_frame_done && (pend_q || i_swap_req)) begin
            front_d = ~front_q;
            pend_d  = 1'b0;
        end else if (i_swap_req) begin
            pend_d = 1'b1;
        end
    end

    // The bank is taken from the post-swap value so commands match o_front_bank.
    always_comb begin
        state_d  = IDLE;
        addr_d   = '0;
        wdata_d  = '0;
        starve_d = starve_q;
        unique case (1'b1)
            rd_win: begin
                state_d = RD;
                addr_d  = {front_d, i_rd_addr};
            end
            wr_win: begin
                state_d = WR;
                addr_d  = {~front_d, i_wr_addr};
                wdata_d = i_wr_data;
            end
            default: ;
        endcase
        if (!i_wr_req || wr_win) begin
            starve_d = '0;
        end else if (wr_elig && !starve_full) begin
            starve_d = starve_q + cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            front_q    <= 1'b0;
            pend_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            front_q    <= front_d;
            pend_q     <= pend_d;
            rd_valid_q <= (state_q == RD);
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign o_rd_gnt       = (state_q == RD);
    assign o_wr_gnt       = (state_q == WR);
    assign o_mem_en       = (state_q != IDLE);
    assign o_mem_we       = (state_q == WR);
    assign o_mem_addr     = addr_q;
    assign o_mem_wdata    = wdata_q;
    assign o_rd_valid     = rd_valid_q;
    assign o_rd_data      = i_mem_rdata;
    assign o_front_bank   = front_q;
    assign o_swap_pending = pend_q;

endmodule
